frame_step_monitor: RTL and testbench



---
 rtl/frame_step_monitor.sv | 186 ++++++++++++++++++
 tb/tb_frame_step_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_step_monitor.sv
// frame_step_monitor
//   Frame-synchronous monitor/controller next to the VGA pixel generator.
//   Builds a CRC-16-CCITT signature over each frame's active area, counts
//   completed frames and issues the robot step pulse on frame boundaries
//   (free-run every N frames, paused, or single-step).
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   pix_en                : pixel qualifier, one clk per scan position
//   pixel_x, pixel_y      : current scan position
//   vga_r, vga_g, vga_b   : colour of the current pixel
//   run_en                : 1 = free-run stepping, 0 = paused
//   step_req              : single-step request (rising edge used)
//   step_div              : frames per step in run mode, 0 behaves as 1
//   robot_step            : one-clk step pulse, only together with frame_done
//   frame_done            : one-clk pulse after each frame end
//   frame_sig, sig_valid  : CRC of the last frame and whether it was complete
//   frame_count           : completed frames since reset (wraps)
//   mode                  : 00 PAUSED, 01 RUNNING, 10 STEP_ARMED
module frame_step_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOR_W  = 8,
    parameter int FCNT_W   = 16,
    parameter int DIV_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [X_W-1:0]     pixel_x,
    input  logic [Y_W-1:0]     pixel_y,
    input  logic [COLOR_W-1:0] vga_r,
    input  logic [COLOR_W-1:0] vga_g,
    input  logic [COLOR_W-1:0] vga_b,
    input  logic               run_en,
    input  logic               step_req,
    input  logic [DIV_W-1:0]   step_div,
    output logic               robot_step,
    output logic               frame_done,
    output logic [15:0]        frame_sig,
    output logic               sig_valid,
    output logic [FCNT_W-1:0]  frame_count,
    output logic [1:0]         mode
);

    typedef enum logic [1:0] {
        PAUSED     = 2'b00,
        RUNNING    = 2'b01,
        STEP_ARMED = 2'b10
    } mode_t;

    localparam logic [X_W-1:0] LP_H    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] LP_V    = Y_W'(V_ACTIVE);
    localparam int             PIX_W   = 3 * COLOR_W;

    // Whole pixel absorbed MSB first in a single clock.
    function automatic logic [15:0] crc_absorb(input logic [15:0] c,
                                               input logic [PIX_W-1:0] d);
        logic [15:0] v;
        v = c;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ 16'h1021;
            else              v = {v[14:0], 1'b0};
        end
        return v;
    endfunction

    mode_t             r_mode;
    logic [DIV_W-1:0]  r_div;
    logic [15:0]       r_crc;
    logic [15:0]       r_frame_sig;
    logic              r_started;
    logic              r_step_q;
    logic              r_prev_vld;
    logic [X_W-1:0]    r_prev_x;
    logic [Y_W-1:0]    r_prev_y;
    logic              r_robot_step;
    logic              r_frame_done;
    logic              r_sig_valid;
    logic [FCNT_W-1:0] r_frame_count;

    logic             w_active;
    logic             w_origin;
    logic             w_same_pos;
    logic             w_frame_end;
    logic             w_step_rise;
    logic [PIX_W-1:0] w_pixel;
    logic [DIV_W:0]   w_div_next;
    logic [DIV_W:0]   w_div_lim;
    logic             w_div_hit;

    assign w_active    = pix_en && (pixel_x < LP_H) && (pixel_y < LP_V);
    assign w_origin    = (pixel_x == '0) && (pixel_y == '0);
    // A frame-end position held over several qualified clks fires only once.
    assign w_same_pos  = r_prev_vld && (r_prev_x == pixel_x) && (r_prev_y == pixel_y);
    assign w_frame_end = pix_en && (pixel_x == '0) && (pixel_y == LP_V) && !w_same_pos;
    assign w_step_rise = step_req && !r_step_q;
    assign w_pixel     = {vga_r, vga_g, vga_b};

    // Divider compared one bit wider so divider+1 cannot wrap.
    assign w_div_next  = {1'b0, r_div} + (DIV_W+1)'(1);
    assign w_div_lim   = (step_div == '0) ? (DIV_W+1)'(1) : {1'b0, step_div};
    assign w_div_hit   = (w_div_next >= w_div_lim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode        <= PAUSED;
            r_div         <= '0;
            r_crc         <= 16'hFFFF;
            r_frame_sig   <= 16'h0000;
            r_started     <= 1'b0;
            r_step_q      <= 1'b0;
            r_prev_vld    <= 1'b0;
            r_prev_x      <= '0;
            r_prev_y      <= '0;
            r_robot_step  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sig_valid   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            r_robot_step <= 1'b0;
            r_step_q     <= step_req;

            if (pix_en) begin
                r_prev_vld <= 1'b1;
                r_prev_x   <= pixel_x;
                r_prev_y   <= pixel_y;
            end

            // Sticky: once the origin has been seen, every later frame is complete.
            if (w_active && w_origin) r_started <= 1'b1;

            // Frame end sits on row V_ACTIVE, so it never coincides with an
            // active pixel and the running CRC can simply restart.
            if (w_frame_end) begin
                r_frame_sig   <= r_crc;
                r_sig_valid   <= r_started;
                r_frame_count <= r_frame_count + FCNT_W'(1);
                r_crc         <= 16'hFFFF;
            end else if (w_active) begin
                r_crc <= crc_absorb(r_crc, w_pixel);
            end

            case (r_mode)
                PAUSED: begin
                    if (run_en)           r_mode <= RUNNING;
                    else if (w_step_rise) r_mode <= STEP_ARMED;
                end
                RUNNING: begin
                    if (!run_en) begin
                        r_mode <= PAUSED;
                        r_div  <= '0;
                    end else if (w_frame_end) begin
                        if (w_div_hit) begin
                            r_robot_step <= 1'b1;
                            r_div        <= '0;
                        end else begin
                            r_div <= w_div_next[DIV_W-1:0];
                        end
                    end
                end
                STEP_ARMED: begin
                    // Run takes priority over a pending single step.
                    if (run_en) begin
                        r_mode <= RUNNING;
                    end else if (w_frame_end) begin
                        r_robot_step <= 1'b1;
                        r_mode       <= PAUSED;
                    end
                end
                default: r_mode <= PAUSED;
            endcase
        end
    end

    assign robot_step  = r_robot_step;
    assign frame_done  = r_frame_done;
    assign frame_sig   = r_frame_sig;
    assign sig_valid   = r_sig_valid;
    assign frame_count = r_frame_count;
    assign mode        = r_mode;

endmodule

// File: tb/tb_frame_step_monitor.sv
// Scoreboard bench for frame_step_monitor: a frame-level reference model
// pushes expected frame_done responses, a negedge monitor pops and compares.
module tb_frame_step_monitor;
    localparam int H = 4, V = 2, XW = 3, YW = 3, CW = 8, FW = 3, DW = 8;
    localparam int HT = 6, VT = 4;   // total scan size including blanking

    logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0, run_en = 1'b0, step_req = 1'b0;
    logic [XW-1:0] pixel_x = '0;
    logic [YW-1:0] pixel_y = '0;
    logic [CW-1:0] vga_r = '0, vga_g = '0, vga_b = '0;
    logic [DW-1:0] step_div = '0;
    logic          robot_step, frame_done, sig_valid;
    logic [15:0]   frame_sig;
    logic [FW-1:0] frame_count;
    logic [1:0]    mode;

    always #5 clk = ~clk;

    frame_step_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW),
                         .COLOR_W(CW), .FCNT_W(FW), .DIV_W(DW)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .run_en(run_en), .step_req(step_req), .step_div(step_div),
        .robot_step(robot_step), .frame_done(frame_done), .frame_sig(frame_sig),
        .sig_valid(sig_valid), .frame_count(frame_count), .mode(mode));

    typedef struct {
        bit        step;
        bit [15:0] sig;
        bit        valid;
        int        cnt;
        int        md;
    } exp_t;
    exp_t sbq[$];

    int tests = 0, fails = 0;
    int n_done = 0, n_step = 0;
    bit        step_hist[$];
    bit [15:0] sig_hist[$];
    int gap_pct = 0;
    bit rnd_step = 0;

    // Reference model state: 0 paused, 1 running, 2 step armed.
    int m_mode, m_div, m_cnt, m_px, m_py;
    bit [15:0] m_crc;
    bit m_started, m_sq, m_pvld;

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [15:0] ref_crc(bit [15:0] c, bit [23:0] d);
        bit fb;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_div = 0; m_cnt = 0; m_crc = 16'hFFFF;
        m_started = 0; m_sq = 0; m_pvld = 0; m_px = 0; m_py = 0;
    endtask

    // Drive one clock's worth of inputs, predict that edge, wait to the next negedge.
    task automatic tick(bit pe, int x, int y, int r, int g, int b);
        bit fe, rise, stp;
        int lim;
        exp_t e;
        if (rnd_step) step_req = ($urandom_range(0, 7) == 0);
        pix_en = pe; pixel_x = XW'(x); pixel_y = YW'(y);
        vga_r = CW'(r); vga_g = CW'(g); vga_b = CW'(b);

        fe = pe && x == 0 && y == V && !(m_pvld && m_px == x && m_py == y);
        if (pe) begin m_pvld = 1; m_px = x; m_py = y; end
        rise = step_req && !m_sq;
        m_sq = step_req;
        stp  = 0;
        lim  = (step_div == 0) ? 1 : int'(step_div);
        case (m_mode)
            0: if (run_en) m_mode = 1; else if (rise) m_mode = 2;
            1: if (!run_en) begin m_mode = 0; m_div = 0; end
               else if (fe) begin
                   if (m_div + 1 >= lim) begin stp = 1; m_div = 0; end
                   else m_div++;
               end
            default: if (run_en) m_mode = 1;
                     else if (fe) begin stp = 1; m_mode = 0; end
        endcase
        if (fe) begin
            m_cnt   = (m_cnt + 1) % (1 << FW);
            e.step  = stp; e.sig = m_crc; e.valid = m_started;
            e.cnt   = m_cnt; e.md = m_mode;
            sbq.push_back(e);
            m_crc   = 16'hFFFF;
        end
        if (pe && x < H && y < V) begin
            m_crc = ref_crc(m_crc, {r[7:0], g[7:0], b[7:0]});
            if (x == 0 && y == 0) m_started = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0);
    endtask

    // pat: 0 all black, 1 random colours, 2 black with (1,0) red = FF
    task automatic scan_rows(int y0, int y1, int pat, int hold);
        int r, g, b;
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < HT; x++) begin
                if ($urandom_range(0, 99) < gap_pct)
                    tick(0, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                r = 0; g = 0; b = 0;
                if (pat == 1) begin
                    r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
                end else if (pat == 2 && x == 1 && y == 0) r = 255;
                tick(1, x, y, r, g, b);
                if (x == 0 && y == V) repeat (hold - 1) tick(1, x, y, r, g, b);
            end
        end
    endtask

    // Each call opens with a frame end (reporting the previous frame), then scans a new one.
    task automatic frame(int pat, int hold);
        scan_rows(V, VT - 1, pat, hold);
        scan_rows(0, V - 1, pat, 1);
    endtask

    task automatic pulse_reset();
        pix_en = 0;
        #2 reset = 1;
        #1;
        check("rst_robot_step", robot_step, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_sig", frame_sig, 0);
        check("rst_sig_valid", sig_valid, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_mode", mode, 0);
        @(negedge clk);
        #2 reset = 0;
        sbq.delete();
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (robot_step && !frame_done) begin
                tests++; fails++;
                $display("FAIL step_without_done: robot_step=1 frame_done=0");
            end
            if (frame_done) begin
                n_done++;
                if (robot_step) n_step++;
                step_hist.push_back(robot_step);
                sig_hist.push_back(frame_sig);
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame_done: got frame_done with empty scoreboard");
                end else begin
                    e = sbq.pop_front();
                    check("sb_robot_step", robot_step, e.step);
                    check("sb_frame_sig", frame_sig, e.sig);
                    check("sb_sig_valid", sig_valid, e.valid);
                    check("sb_frame_count", frame_count, e.cnt);
                    check("sb_mode", mode, e.md);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int b, s;
        model_reset();
        repeat (3) @(negedge clk);
        check("init_frame_sig", frame_sig, 0);
        check("init_frame_count", frame_count, 0);
        check("init_mode", mode, 0);
        check("init_frame_done", frame_done, 0);
        #2 reset = 0;

        // Paused, black frames: no steps, first report is partial.
        repeat (3) frame(0, 1);
        check("t1_done_count", n_done, 3);
        check("t1_frame_count", frame_count, 3);
        check("t1_no_steps", n_step, 0);

        // Single red pixel changes only its own frame's signature.
        frame(2, 1); frame(0, 1); frame(0, 1);
        s = sig_hist.size();
        check("pix_sig_differs_prev", sig_hist[s-2] != sig_hist[s-3], 1);
        check("pix_sig_differs_next", sig_hist[s-2] != sig_hist[s-1], 1);
        check("pix_sig_same_3_5", sig_hist[s-3], sig_hist[s-1]);

        // Free run every 3 frames, then every frame, then a lowered divisor.
        gap_pct = 15;
        idle(2); run_en = 1; step_div = 3; idle(2);
        b = step_hist.size();
        repeat (7) frame(1, 1);
        for (int i = 0; i < 7; i++) check($sformatf("run_div3_%0d", i), step_hist[b+i], (i % 3 == 2));
        step_div = 0;
        b = step_hist.size();
        repeat (3) frame(1, 1);
        for (int i = 0; i < 3; i++) check($sformatf("run_div0_%0d", i), step_hist[b+i], 1);
        step_div = 5;
        b = step_hist.size();
        repeat (2) frame(1, 1);
        step_div = 1;
        frame(1, 1);
        check("lower_div_a", step_hist[b], 0);
        check("lower_div_b", step_hist[b+1], 0);
        check("lower_div_fire", step_hist[b+2], 1);

        // Single step with a duplicate request before the frame end.
        run_en = 0; idle(2);
        check("pause_mode", mode, 0);
        scan_rows(V, VT - 1, 1, 1);
        scan_rows(0, 0, 1, 1);
        step_req = 1; idle(1); step_req = 0; idle(1);
        check("armed_mode", mode, 2);
        step_req = 1; idle(1); step_req = 0; idle(1);
        check("armed_mode_dup", mode, 2);
        scan_rows(1, V - 1, 1, 1);
        b = n_step;
        scan_rows(V, VT - 1, 1, 1);
        check("single_step_once", n_step - b, 1);
        check("single_step_paused", mode, 0);
        scan_rows(0, V - 1, 1, 1);
        frame(1, 1);
        check("single_step_no_more", n_step - b, 1);

        // Frame end held for three qualified clocks counts once.
        b = n_done;
        frame(1, 3);
        idle(3);
        check("hold_single_done", n_done - b, 1);

        // Reset mid-frame: next report is partial and counts from one.
        scan_rows(V, VT - 1, 1, 1);
        scan_rows(0, 0, 1, 1);
        pulse_reset();
        scan_rows(1, V - 1, 1, 1);
        scan_rows(V, VT - 1, 1, 1);
        check("post_rst_valid", sig_valid, 0);
        check("post_rst_count", frame_count, 1);
        scan_rows(0, V - 1, 1, 1);

        // Counter wraps at 2^FW.
        repeat (7) frame(1, 1);
        check("count_wrap", frame_count, 0);

        // Randomised mode traffic.
        rnd_step = 1; gap_pct = 25;
        repeat (14) begin
            run_en   = ($urandom_range(0, 2) == 0);
            step_div = DW'($urandom_range(0, 4));
            frame(1, $urandom_range(1, 3));
        end
        rnd_step = 0; step_req = 0;
        idle(4);
        check("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
